wb_spram_port: RTL
==================

// Module: wb_spram_port
// PURPOSE
//  Wishbone B4 pipelined slave that owns the command side of a single-port 32-bit byte-write SRAM.
//  Drives its addr/ce/we/d inputs and returns its registered q to the bus.
//  Optionally zero-fills the array after reset, stalling the bus until clear completes.
//  Sits between the SoC interconnect and each on-chip RAM instance (the RAM is instantiated by the parent).
// PARAMETERS
//  SIZE            'h80              RAM size in bytes; power of two, >= 8
//  ADDR_WIDTH      $clog2(SIZE)-2    RAM word-address width
//  CLEAR_ON_RESET  1                 1: zero-fill every word after reset; 0: skip clear
// PORTS
//  clk        in   1           clock; all logic on posedge
//  rst_n      in   1           synchronous reset, active low
//  wb_cyc     in   1           bus cycle active
//  wb_stb     in   1           request strobe
//  wb_we      in   1           1 = write
//  wb_adr     in   32          byte address; bits [1:0] ignored
//  wb_sel     in   4           byte lane selects
//  wb_dat_i   in   32          write data
//  wb_dat_o   out  32          read data, valid with wb_ack
//  wb_ack     out  1           access complete
//  wb_err     out  1           access to address >= SIZE
//  wb_stall   out  1           request not accepted this cycle
//  ram_addr   out  ADDR_WIDTH  RAM word address
//  ram_ce     out  1           RAM chip enable
//  ram_we     out  4           RAM byte write enables
//  ram_d      out  32          RAM write data
//  ram_q      in   32          RAM read data, registered (1-cycle latency after ce)
//  init_done  out  1           clear finished, bus serviced
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): ack=0, err=0, dat_o=0, init_done=0, clear counter=0.
//    State goes to CLEAR if CLEAR_ON_RESET, else RUN. wb_stall=1 while rst_n=0.
//  - FSM:
//    - CLEAR: ram_ce=1, ram_we=4'hF, ram_d=0, ram_addr=counter; counter += 1 each cycle.
//      wb_stall=1, no ack/err. After word SIZE/4-1 is written, go to RUN next cycle.
//      Clear takes exactly SIZE/4 cycles.
//    - RUN: init_done=1 and wb_stall=0 permanently. No other transitions except reset.
//  - Accept in cycle N when wb_cyc & wb_stb & !wb_stall. stb with cyc=0 is ignored.
//  - Accepted, in range (wb_adr[31:$clog2(SIZE)]==0), combinational in cycle N:
//      ram_ce=1, ram_addr=wb_adr[ADDR_WIDTH+1:2], ram_d=wb_dat_i, ram_we = wb_we ? wb_sel : 4'h0.
//  - Accepted, out of range: ram_ce=0; wb_err=1 in N+1, wb_ack=0, wb_dat_o=0.
//  - In range: wb_ack=1 in N+1 (single cycle).
//    wb_dat_o = ram_q for a read, 32'h0 for a write. Fixed latency 1 for reads and writes.
//  - Not accepting in RUN: ram_ce=0, ram_we=0; ram_addr/ram_d are don't-care.
//  - Throughput: one access per cycle, back-to-back with no bubbles. Read-after-write to the same
//    word in consecutive cycles returns the new data (the RAM write is done before the read edge).
//  - Write with wb_sel=0: accepted and acked; no byte changes (ce=1, we=0).
//  - wb_cyc dropped after acceptance: the RAM access still completes and ack/err still pulses in
//    N+1; masters ignore it.
//  - Reset mid-clear or mid-access: pending ack/err is discarded and the clear restarts from word 0.
//    A write already issued at the reset edge may or may not have landed.
//  - ack and err are never both 1. Neither is asserted without an acceptance one cycle earlier.
// STRUCTURE
//  - Package wb_spram_pkg: typedef enum logic {ST_CLEAR, ST_RUN} state_t; WB_AW=32, WB_DW=32,
//    WB_SW=4 constants.
//  - Flat module, no sub-module: state_t register, ADDR_WIDTH-bit clear counter, and 1-cycle
//    response pipe {ack, err, is_read}.
//  - RAM-side outputs are combinational from the state and the accept term.
// TESTING (SIZE='h80, CLEAR_ON_RESET=1, bench instantiates spramx32 behind the port)
//  1. Preload RAM with 32'hDEADBEEF, release reset -> stall=1 for exactly 32 cycles, then
//     init_done=1; reading all 32 words returns 0.
//  2. Write 0x10=32'h11223344 sel=4'hF, then write 0x10=32'hAABBCCDD sel=4'b0101, read 0x10
//     -> 32'h11BB33DD; each ack exactly 1 cycle after its accept.
//  3. Back-to-back writes to 0x00..0x7C then back-to-back reads -> one ack per cycle, data in
//     order, no stall.
//  4. Read 0x80 and write 0xFFFF_0000 -> wb_err=1 in N+1, ack=0, ram_ce never 1, RAM unchanged.
//  5. Write 0x04=32'hCAFEF00D, read 0x04 in the very next cycle -> 32'hCAFEF00D.
//  6. Assert rst_n=0 at clear word 10 and during an outstanding read -> no ack;
//     the clear restarts and takes a full 32 cycles.

Source files
------------

// File: rtl/wb_spram_pkg.sv
// Shared types and bus-width constants for the Wishbone single-port RAM command port.
// Imported by wb_spram_port.
package wb_spram_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/wb_spram_port.sv
// Wishbone B4 pipelined slave that drives the command side of a single-port byte-write SRAM,
// with an optional zero-fill of the whole array after reset.
module wb_spram_port
    import wb_spram_pkg::*;
#(
    parameter int SIZE           = 'h80,
    parameter int ADDR_WIDTH     = $clog2(SIZE) - 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [WB_AW-1:0]      wb_adr,
    input  logic [WB_SW-1:0]      wb_sel,
    input  logic [WB_DW-1:0]      wb_dat_i,
    output logic [WB_DW-1:0]      wb_dat_o,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  wb_stall,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_ce,
    output logic [WB_SW-1:0]      ram_we,
    output logic [WB_DW-1:0]      ram_d,
    input  logic [WB_DW-1:0]      ram_q,
    output logic                  init_done
);

    localparam int SIZE_LOG2 = $clog2(SIZE);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_is_read;
    logic                  r_init_done;

    logic w_accept;
    logic w_in_range;
    logic w_unused;

    // Byte-offset bits never reach the RAM; word addressing only.
    assign w_unused   = ^wb_adr[1:0];

    assign wb_stall   = !rst_n || !r_init_done;
    assign w_accept   = wb_cyc && wb_stb && !wb_stall;
    assign w_in_range = (wb_adr[WB_AW-1:SIZE_LOG2] == '0);

    assign wb_ack     = r_ack;
    assign wb_err     = r_err;
    assign init_done  = r_init_done;
    // ram_q is the registered result of the access accepted last cycle.
    assign wb_dat_o   = (r_ack && r_is_read) ? ram_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_cnt   <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_is_read   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
            end
            r_ack     <= w_accept && w_in_range;
            r_err     <= w_accept && !w_in_range;
            r_is_read <= !wb_we;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_ce      = 1'b0;
        ram_we      = '0;
        ram_addr    = wb_adr[ADDR_WIDTH+1:2];
        ram_d       = wb_dat_i;
        case (r_state)
            ST_CLEAR: begin
                if (rst_n) begin
                    ram_ce   = 1'b1;
                    ram_we   = '1;
                    ram_d    = '0;
                    ram_addr = r_clr_cnt;
                    if (r_clr_cnt == '1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept && w_in_range) begin
                    ram_ce = 1'b1;
                    ram_we = wb_we ? wb_sel : '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
